// File: rtl/alu_param.sv
// Registered signed ALU: single-cycle logic/arith ops, iterative radix-2 Booth multiply.
// Define ALU_ITER_DIV_EN to build the iterative non-restoring divider (ops DIV/REM).
module alu_param #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] out,
   output logic             overflow,
   output logic             zero,
   output logic             err,
   output logic             busy,
   output logic             done
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER, DIV_FIX} state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_MUL  = 4'b0010, OP_DIV = 4'b0011,
      OP_SHL  = 4'b0100, OP_SHR  = 4'b0101, OP_XOR  = 4'b0110, OP_XNOR = 4'b0111,
      OP_NOT  = 4'b1000, OP_AND  = 4'b1001, OP_OR   = 4'b1010, OP_MULH = 4'b1011,
      OP_REM  = 4'b1100, OP_ASR  = 4'b1101
   } op_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             sel_q;
   logic             accept;

   logic             ld;
   logic [WIDTH-1:0] res;
   logic             res_ovf, res_err;
   logic [WIDTH-1:0] add_s, sub_s;

   logic [WIDTH:0]   macc, mcand, msum, macc_nxt;
   logic [WIDTH-1:0] mq, mq_nxt;
   logic             mq_m1;
   logic [WIDTH-1:0] prod_hi, prod_lo;
   logic             mul_ovf;

`ifdef ALU_ITER_DIV_EN
   localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH+1:0] drem, dshift, drem_nxt;
   logic [WIDTH-1:0] dq, dq_nxt, dd, rmag;
   logic [WIDTH-1:0] amag, bmag;
   logic             qneg_q, rneg_q, dovf_q;
`endif

   assign accept = (state == IDLE) && start;
   assign busy   = (state != IDLE);
   assign zero   = (out == '0);
   assign add_s  = A + B;
   assign sub_s  = A - B;

   // Booth step on {macc, mq, mq_m1}; the extra acc bit absorbs -MINNEG
   always_comb begin
      case ({mq[0], mq_m1})
         2'b01:   msum = macc + mcand;
         2'b10:   msum = macc - mcand;
         default: msum = macc;
      endcase
      macc_nxt = {msum[WIDTH], msum[WIDTH:1]};
      mq_nxt   = {msum[0], mq[WIDTH-1:1]};
      prod_hi  = macc_nxt[WIDTH-1:0];
      prod_lo  = mq_nxt;
      mul_ovf  = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
   end

`ifdef ALU_ITER_DIV_EN
   // Divide magnitudes; signs are applied in DIV_FIX, only the remainder needs restoring
   always_comb begin
      amag     = A[WIDTH-1] ? -A : A;
      bmag     = B[WIDTH-1] ? -B : B;
      dshift   = {drem[WIDTH:0], dq[WIDTH-1]};
      drem_nxt = drem[WIDTH+1] ? dshift + {2'b00, dd} : dshift - {2'b00, dd};
      dq_nxt   = {dq[WIDTH-2:0], ~drem_nxt[WIDTH+1]};
      rmag     = drem[WIDTH+1] ? drem[WIDTH-1:0] + dd : drem[WIDTH-1:0];
   end
`endif

   always_comb begin
      state_nxt = state;
      ld        = 1'b0;
      res       = '0;
      res_ovf   = 1'b0;
      res_err   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               ld = 1'b1;
               case (op)
                  OP_ADD: begin
                     res     = add_s;
                     res_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
                  end
                  OP_SUB: begin
                     res     = sub_s;
                     res_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]);
                  end
                  OP_MUL, OP_MULH: begin
                     ld        = 1'b0;
                     state_nxt = MUL_ITER;
                  end
`ifdef ALU_ITER_DIV_EN
                  OP_DIV, OP_REM: begin
                     if (B == '0) begin
                        res_err = 1'b1;
                        res     = (op == OP_DIV) ? '1 : A;
                     end else begin
                        ld        = 1'b0;
                        state_nxt = DIV_ITER;
                     end
                  end
`endif
                  OP_SHL:  res = A << B;
                  OP_SHR:  res = A >> B;
                  OP_ASR:  res = $signed(A) >>> B;
                  OP_XOR:  res = A ^ B;
                  OP_XNOR: res = ~(A ^ B);
                  OP_NOT:  res = ~A;
                  OP_AND:  res = A & B;
                  OP_OR:   res = A | B;
                  default: res_err = 1'b1;
               endcase
            end
         end
         MUL_ITER: begin
            if (cnt == CW'(WIDTH - 1)) begin
               state_nxt = IDLE;
               ld        = 1'b1;
               res       = sel_q ? prod_hi : prod_lo;
               res_ovf   = ~sel_q & mul_ovf;
            end
         end
`ifdef ALU_ITER_DIV_EN
         DIV_ITER: begin
            if (cnt == CW'(WIDTH - 1)) state_nxt = DIV_FIX;
         end
         DIV_FIX: begin
            state_nxt = IDLE;
            ld        = 1'b1;
            res       = sel_q ? (rneg_q ? -rmag : rmag) : (qneg_q ? -dq : dq);
            res_ovf   = ~sel_q & dovf_q;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out      <= '0;
         overflow <= 1'b0;
         err      <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         sel_q    <= 1'b0;
         macc     <= '0;
         mcand    <= '0;
         mq       <= '0;
         mq_m1    <= 1'b0;
`ifdef ALU_ITER_DIV_EN
         drem     <= '0;
         dq       <= '0;
         dd       <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dovf_q   <= 1'b0;
`endif
      end else begin
         done <= ld;
         if (ld) begin
            out      <= res;
            overflow <= res_ovf;
            err      <= res_err;
         end
         if (accept) begin
            cnt   <= '0;
            sel_q <= op[3];
            macc  <= '0;
            mcand <= {B[WIDTH-1], B};
            mq    <= A;
            mq_m1 <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            drem   <= '0;
            dq     <= amag;
            dd     <= bmag;
            qneg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            rneg_q <= A[WIDTH-1];
            dovf_q <= (A == MINNEG) && (B == '1);
`endif
         end else begin
            cnt <= cnt + CW'(1);
            if (state == MUL_ITER) begin
               macc  <= macc_nxt;
               mq    <= mq_nxt;
               mq_m1 <= mq[0];
            end
`ifdef ALU_ITER_DIV_EN
            if (state == DIV_ITER) begin
               drem <= drem_nxt;
               dq   <= dq_nxt;
            end
`endif
         end
      end
   end
endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (legal range 8..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL have port op  input  4  operation code, captured on accept.
REQ-006 SHALL have ports A, B  input  WIDTH each  signed operands, captured on accept.
REQ-007 SHALL have port out  output  WIDTH  signed registered result.
REQ-008 SHALL have port overflow  output  1  signed overflow of the last result.
REQ-009 SHALL have port zero  output  1  high when out==0.
REQ-010 SHALL have port err  output  1  divide-by-zero or reserved/disabled op.
REQ-011 SHALL have port busy  output  1  high while an operation is in flight.
REQ-012 SHALL have port done  output  1  one-cycle pulse when out/flags update.

Function
REQ-013 SHALL implement these op codes: 0000 ADD, 0001 SUB, 0010 MUL (low WIDTH bits, radix-2 Booth), 0011 DIV (signed, truncates toward zero, non-restoring), 0100 SHL, 0101 SHR logical, 0110 XOR, 0111 XNOR, 1000 NOT A, 1001 AND, 1010 OR, 1011 MULH (high WIDTH bits of the signed 2*WIDTH product), 1100 REM (sign of A), 1101 ASR; 1110/1111 reserved.
REQ-014 SHALL use FSM states IDLE, MUL_ITER, DIV_ITER, DIV_FIX: IDLE->MUL_ITER on accepted MUL/MULH; IDLE->DIV_ITER on accepted DIV/REM with B!=0; DIV_ITER->DIV_FIX after WIDTH iterations; MUL_ITER and DIV_FIX return to IDLE.
REQ-015 SHALL treat single-cycle ops, reserved ops and DIV/REM with B==0 as IDLE->IDLE: out valid and done=1 on the cycle after the accept edge.
REQ-016 SHALL assert done exactly WIDTH+1 cycles after accept for MUL/MULH, and WIDTH+2 cycles after accept for DIV/REM.
REQ-017 SHALL hold busy=1 from the cycle after accept until the cycle done is asserted, and SHALL hold busy=0 during that done cycle.
REQ-018 SHALL ignore start while busy=1, with captured operands unaffected.
REQ-019 SHALL allow start with done=1 and busy=0 (back-to-back) to be accepted.
REQ-020 SHALL hold out, overflow, zero and err between done pulses.
REQ-021 SHALL take the shift amount as B unsigned; for B>=WIDTH, SHL/SHR SHALL give 0 and ASR SHALL give all copies of A[WIDTH-1].
REQ-022 SHALL set overflow: ADD/SUB on signed overflow; MUL when the product does not fit in signed WIDTH bits; DIV when A=most-negative and B=-1 (out=A); 0 for all other ops.
REQ-023 SHALL handle B==0 for DIV/REM with err=1, DIV out=all ones, REM out=A, overflow=0.
REQ-024 SHALL handle reserved ops with out=0 and err=1.
REQ-025 SHALL compute zero from the registered out value.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, set state=IDLE and out=0, overflow=0, zero=1, err=0, busy=0, done=0.
REQ-027 SHALL abort any in-flight MUL/DIV on reset, with no done pulse for it; reset SHALL have priority over start.

Configuration
REQ-028 SHALL compile in the iterative divider (DIV_ITER/DIV_FIX, ops 0011/1100) when ALU_ITER_DIV_EN is defined.
REQ-029 SHALL, when ALU_ITER_DIV_EN is undefined, complete ops 0011/1100 as reserved (1-cycle, out=0, err=1) with no divider logic present.

Verification (WIDTH=16, ALU_ITER_DIV_EN defined)
REQ-030 SHALL cover ADD A=-529, B=10 -> out=0xFDF9 (-519), done 1 cycle after accept, overflow=0, zero=0.
REQ-031 SHALL cover MUL A=30, B=-41 -> out=0xFB32 (-1230), done 17 cycles after accept; MULH with same operands -> 0xFFFF; MUL 0x4000*4 -> overflow=1.
REQ-032 SHALL cover DIV 16900/20 -> 845 at 18 cycles; DIV -7/2 -> -3; REM -7/2 -> -1; DIV 0x8000/-1 -> out=0x8000, overflow=1.
REQ-033 SHALL cover DIV 80/0 -> out=0xFFFF, err=1, done 1 cycle after accept; REM 80/0 -> out=80.
REQ-034 SHALL cover start pulsed mid-MUL with new operands -> ignored, original product returned; reset at iteration 5 -> busy=0, out=0, zero=1, no done pulse.
REQ-035 SHALL cover ASR A=0x8000, B=20 -> 0xFFFF; SHR same -> 0; op 1111 -> out=0, err=1.
